rc4_plaintext_checker: RTL and testbench

Parametrised successor to the RC4 key-search plaintext checker. Walks MSG_LEN bytes of decrypted output memory (D RAM), checks each byte against a run-time selectable character class, and reports pass/fail, the first failing address and the count of bytes passed. Sits between the RC4 decrypt FSM and the key-search controller, using the same Start/Finish/ack handshake.

---
 rtl/rc4_plaintext_checker.sv | 122 ++++++++++++
 tb/tb_rc4_plaintext_checker.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_plaintext_checker.sv
// RC4 key-search plaintext checker: walks MSG_LEN bytes of D RAM and checks each
// against a run-time character class, reporting pass/fail, first failing address and pass count.
module rc4_plaintext_checker #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 5,
    parameter int RD_LAT  = 2
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              Checker_Start,
    input  logic              Finish_ack,
    input  logic [1:0]        Mode,
    input  logic [7:0]        q_D,
    output logic [ADDR_W-1:0] Address,
    output logic              Busy,
    output logic              Checker_Finish,
    output logic              Decrypt_Valid,
    output logic [ADDR_W-1:0] Fail_Addr,
    output logic [ADDR_W:0]   Valid_Count
);
    // state | meaning
    // IDLE  | waiting for Checker_Start; results of the last run held
    // WAIT  | byte at Address in flight; compared when the read timer reaches zero
    // DONE  | Checker_Finish high, results held until Finish_ack
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam int                CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] fail_q;
    logic [ADDR_W:0]   vcnt_q;
    logic              busy_q;
    logic              fin_q;
    logic              valid_q;
    logic              byte_ok_d;

    function automatic logic char_ok(input logic [1:0] mode, input logic [7:0] c);
        logic space, lower, upper, digit;
        space = (c == 8'h20);
        lower = (c >= 8'h61) && (c <= 8'h7A);
        upper = (c >= 8'h41) && (c <= 8'h5A);
        digit = (c >= 8'h30) && (c <= 8'h39);
        case (mode)
            2'd1:    char_ok = (c >= 8'h20) && (c <= 8'h7E);
            2'd2:    char_ok = space | lower | upper | digit;
            default: char_ok = space | lower;
        endcase
    endfunction

    assign byte_ok_d = char_ok(mode_q, q_D);

    // Down-counter loaded with RD_LAT-1 so the compare lands exactly RD_LAT edges after Address moves.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 2'd0;
            addr_q  <= '0;
            fail_q  <= '0;
            vcnt_q  <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Checker_Start) begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_LOAD;
                        mode_q  <= Mode;
                        addr_q  <= '0;
                        fail_q  <= '0;
                        vcnt_q  <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (!byte_ok_d) begin
                        fail_q  <= addr_q;
                        valid_q <= 1'b0;
                        fin_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        vcnt_q <= vcnt_q + (ADDR_W+1)'(1);
                        if (addr_q == LAST_IDX) begin
                            valid_q <= 1'b1;
                            fin_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                            cnt_q  <= CNT_LOAD;
                        end
                    end
                end
                DONE: begin
                    if (Finish_ack) begin
                        state_q <= IDLE;
                        fin_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Address        = addr_q;
    assign Busy           = busy_q;
    assign Checker_Finish = fin_q;
    assign Decrypt_Valid  = valid_q;
    assign Fail_Addr      = fail_q;
    assign Valid_Count    = vcnt_q;

endmodule

// File: tb/tb_rc4_plaintext_checker.sv
// Scoreboard bench for rc4_plaintext_checker: three instances (MSG_LEN/RD_LAT = 4/2, 32/1, 32/4)
// fed by latency-accurate RAM models; expected results come from a character-class reference model.
module tb_rc4_plaintext_checker;
    localparam int NI = 3;

    typedef struct {
        int inst;
        int fin_cyc;
        int dv;
        int fa;
        int vc;
        int addr_end;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start [NI];
    logic       ack   [NI];
    logic [1:0] mode  [NI];
    logic [7:0] qd    [NI];
    logic [7:0] mem   [NI][32];
    logic [7:0] pipe  [NI][3];

    logic [1:0] addr0, fa0;
    logic [2:0] vc0;
    logic [4:0] addr1, fa1, addr2, fa2;
    logic [5:0] vc1, vc2;
    logic       busy0, busy1, busy2, fin0, fin1, fin2, dv0, dv1, dv2;

    int   addr [NI];
    int   fa   [NI];
    int   vc   [NI];
    int   busy [NI];
    int   fin  [NI];
    int   dv   [NI];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic fin_prev [NI];

    rc4_plaintext_checker #(.MSG_LEN(4), .ADDR_W(2), .RD_LAT(2)) dut0 (
        .CLOCK_50(clk), .rst(rst), .Checker_Start(start[0]), .Finish_ack(ack[0]),
        .Mode(mode[0]), .q_D(qd[0]), .Address(addr0), .Busy(busy0),
        .Checker_Finish(fin0), .Decrypt_Valid(dv0), .Fail_Addr(fa0), .Valid_Count(vc0));

    rc4_plaintext_checker #(.MSG_LEN(32), .ADDR_W(5), .RD_LAT(1)) dut1 (
        .CLOCK_50(clk), .rst(rst), .Checker_Start(start[1]), .Finish_ack(ack[1]),
        .Mode(mode[1]), .q_D(qd[1]), .Address(addr1), .Busy(busy1),
        .Checker_Finish(fin1), .Decrypt_Valid(dv1), .Fail_Addr(fa1), .Valid_Count(vc1));

    rc4_plaintext_checker #(.MSG_LEN(32), .ADDR_W(5), .RD_LAT(4)) dut2 (
        .CLOCK_50(clk), .rst(rst), .Checker_Start(start[2]), .Finish_ack(ack[2]),
        .Mode(mode[2]), .q_D(qd[2]), .Address(addr2), .Busy(busy2),
        .Checker_Finish(fin2), .Decrypt_Valid(dv2), .Fail_Addr(fa2), .Valid_Count(vc2));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        addr[0] = int'(addr0); addr[1] = int'(addr1); addr[2] = int'(addr2);
        fa[0]   = int'(fa0);   fa[1]   = int'(fa1);   fa[2]   = int'(fa2);
        vc[0]   = int'(vc0);   vc[1]   = int'(vc1);   vc[2]   = int'(vc2);
        busy[0] = int'(busy0); busy[1] = int'(busy1); busy[2] = int'(busy2);
        fin[0]  = int'(fin0);  fin[1]  = int'(fin1);  fin[2]  = int'(fin2);
        dv[0]   = int'(dv0);   dv[1]   = int'(dv1);   dv[2]   = int'(dv2);
    end

    // RAM read path: data for an address appears RD_LAT edges after the address is registered.
    always @(posedge clk) begin
        for (int u = 0; u < NI; u++) begin
            pipe[u][0] <= mem[u][addr[u]];
            pipe[u][1] <= pipe[u][0];
            pipe[u][2] <= pipe[u][1];
        end
    end

    always_comb begin
        qd[0] = pipe[0][0];
        qd[1] = mem[1][addr[1]];
        qd[2] = pipe[2][2];
    end

    function automatic int ml(input int u);
        return (u == 0) ? 4 : 32;
    endfunction

    function automatic int rl(input int u);
        return (u == 0) ? 2 : ((u == 1) ? 1 : 4);
    endfunction

    function automatic void chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endfunction

    function automatic bit in_class(input int md, input int c);
        bit sp, lo, up, dg;
        sp = (c == 32);
        lo = c inside {[97:122]};
        up = c inside {[65:90]};
        dg = c inside {[48:57]};
        if (md == 1) return c inside {[32:126]};
        if (md == 2) return sp || lo || up || dg;
        return sp || lo;
    endfunction

    function automatic void model(input int u, input int md, output exp_t e);
        int n;
        n = ml(u);
        e.inst = u; e.dv = 1; e.fa = 0; e.vc = n; e.addr_end = n - 1; e.fin_cyc = n * rl(u);
        for (int i = 0; i < n; i++) begin
            if (!in_class(md, int'(mem[u][i]))) begin
                e.dv = 0; e.fa = i; e.vc = i; e.addr_end = i; e.fin_cyc = (i + 1) * rl(u);
                break;
            end
        end
    endfunction

    // Monitor: on each rising Checker_Finish pop the oldest expectation and compare.
    always @(negedge clk) begin
        for (int u = 0; u < NI; u++) begin
            if (fin[u] == 1 && !fin_prev[u]) begin
                if (sb.size() == 0) begin
                    chk("unexpected_finish_inst", u, -1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("finish_inst", u, e.inst);
                    chk("finish_cycle", cyc, e.fin_cyc);
                    chk("decrypt_valid", dv[u], e.dv);
                    chk("fail_addr", fa[u], e.fa);
                    chk("valid_count", vc[u], e.vc);
                    chk("address_at_finish", addr[u], e.addr_end);
                    chk("busy_at_finish", busy[u], 1);
                end
            end
            fin_prev[u] = (fin[u] == 1);
        end
    end

    task automatic load_str(input int u, input string s);
        for (int i = 0; i < s.len(); i++) mem[u][i] = s[i];
    endtask

    task automatic load4(input int u, input int b0, input int b1, input int b2, input int b3);
        mem[u][0] = 8'(b0); mem[u][1] = 8'(b1); mem[u][2] = 8'(b2); mem[u][3] = 8'(b3);
    endtask

    task automatic fill_lower(input int u);
        for (int i = 0; i < 32; i++) mem[u][i] = 8'(97 + $urandom_range(0, 25));
    endtask

    task automatic fill_rand(input int u);
        int r;
        for (int i = 0; i < 32; i++) begin
            r = $urandom_range(0, 39);
            case (r)
                0:       mem[u][i] = 8'($urandom_range(0, 255));
                1:       mem[u][i] = 8'($urandom_range(48, 57));
                2:       mem[u][i] = 8'($urandom_range(65, 90));
                3:       mem[u][i] = 8'h20;
                4:       mem[u][i] = 8'($urandom_range(33, 47));
                default: mem[u][i] = 8'($urandom_range(97, 122));
            endcase
        end
    endtask

    task automatic run_one(input int u, input int md, input bit disturb, input bit sa_ack);
        exp_t e;
        int   waited;
        int   hold;
        model(u, md, e);
        @(negedge clk);
        mode[u]  = 2'(md);
        start[u] = 1'b1;
        ack[u]   = 1'($urandom_range(0, 1));
        @(negedge clk);
        start[u] = 1'b0;
        ack[u]   = 1'b0;
        mode[u]  = 2'($urandom_range(0, 3));
        e.fin_cyc = e.fin_cyc + cyc;
        sb.push_back(e);
        chk("busy_after_start", busy[u], 1);
        waited = 0;
        while (fin[u] == 0 && waited < 400) begin
            if (disturb) begin
                start[u] = ($urandom_range(0, 3) == 0);
                ack[u]   = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            waited++;
        end
        start[u] = 1'b0;
        ack[u]   = 1'b0;
        chk("finish_seen", fin[u], 1);
        hold = $urandom_range(0, 3);
        repeat (hold) begin
            @(negedge clk);
            chk("finish_held", fin[u], 1);
        end
        ack[u]   = 1'b1;
        start[u] = sa_ack;
        @(negedge clk);
        ack[u]   = 1'b0;
        start[u] = 1'b0;
        chk("finish_dropped", fin[u], 0);
        chk("busy_dropped", busy[u], 0);
        chk("held_valid", dv[u], e.dv);
        chk("held_fail_addr", fa[u], e.fa);
        chk("held_count", vc[u], e.vc);
        if (sa_ack) begin
            repeat (2) begin
                @(negedge clk);
                chk("no_restart_after_start_ack", busy[u], 0);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int u = 0; u < NI; u++) begin
            chk({tag, "_address"}, addr[u], 0);
            chk({tag, "_busy"}, busy[u], 0);
            chk({tag, "_finish"}, fin[u], 0);
            chk({tag, "_valid"}, dv[u], 0);
            chk({tag, "_fail_addr"}, fa[u], 0);
            chk({tag, "_count"}, vc[u], 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < NI; u++) begin
            start[u] = 1'b0; ack[u] = 1'b0; mode[u] = 2'd0; fin_prev[u] = 1'b0;
            for (int i = 0; i < 32; i++) mem[u][i] = 8'h61;
        end
        #2 rst = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        load_str(0, "ab z"); run_one(0, 0, 0, 0);
        load_str(0, "af2z"); run_one(0, 0, 1, 0);
        load_str(0, "aF!z");
        run_one(0, 1, 0, 0);
        run_one(0, 2, 0, 1);
        run_one(0, 0, 1, 0);
        run_one(0, 3, 0, 0);
        load4(0, 8'h20, 8'h7E, 8'h7F, 8'h41); run_one(0, 1, 0, 0);
        load4(0, 8'h61, 8'h7A, 8'h60, 8'h61); run_one(0, 0, 0, 0);
        load4(0, 8'h30, 8'h39, 8'h5A, 8'h40); run_one(0, 2, 1, 0);

        fill_lower(1); run_one(1, 0, 0, 0);
        fill_lower(2); run_one(2, 3, 1, 0);
        mem[1][31] = 8'h7B; run_one(1, 0, 0, 1);
        mem[2][31] = 8'h7B; run_one(2, 2, 0, 0);

        // Asynchronous reset in the middle of a long run, between clock edges.
        fill_lower(2);
        @(negedge clk);
        mode[2]  = 2'd0;
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_finish_after_reset", fin[2], 0);
        fill_rand(2); mem[2][17] = 8'h21; run_one(2, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            int u;
            u = $urandom_range(0, NI - 1);
            fill_rand(u);
            run_one(u, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
